// File: rtl/kpyd_scan_ctrl_if.sv
// kpyd_scan_ctrl_if: keypad matrix lines plus key-code valid/ready handshake.
interface kpyd_scan_ctrl_if;
  logic [3:0] col;
  logic [3:0] row;
  logic [7:0] kpyd;
  logic       valid;
  logic       ready;
  logic       busy;
  modport master (input col, ready, output row, kpyd, valid, busy);
  modport slave  (output col, ready, input row, kpyd, valid, busy);
endinterface

// File: rtl/kpyd_scan_ctrl.sv
// kpyd_scan_ctrl: 4x4 keypad row scanner with debounce and one-hot key code handshake.
module kpyd_scan_ctrl #(
  parameter int SCAN_CYCLES    = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic                clk_i,
  input logic                reset_n_i,
  kpyd_scan_ctrl_if.master   kp
);
  localparam int DW = $clog2(SCAN_CYCLES);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] LAST = DW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] DS = CW'(DEBOUNCE_SCANS);
  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESENT, WAIT_RELEASE} state_t;
  state_t        state;
  logic [3:0]    col_s1, col_s2;
  logic [1:0]    r;
  logic [DW-1:0] dwell;
  logic [15:0]   snap, snap_n;
  logic [CW-1:0] cnt, cnt_inc;
  logic [7:0]    cand, code, kpyd;
  logic          valid, last, scan_done, none, single;
  assign last      = dwell == LAST;
  assign scan_done = last && r == 2'd3;
  assign cnt_inc   = cnt + 1'b1;
  assign kp.row    = 4'b0001 << r;
  assign kp.kpyd   = kpyd;
  assign kp.valid  = valid;
  assign kp.busy   = state != IDLE;
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      col_s1 <= '0;
      col_s2 <= '0;
      r      <= '0;
      dwell  <= '0;
      snap   <= '0;
    end else begin
      col_s1 <= kp.col;
      col_s2 <= col_s1;
      dwell  <= last ? '0 : dwell + 1'b1;
      if (last) begin
        r    <= r + 1'b1;
        snap <= snap_n;
      end
    end
  end
  // Classify the scan including the row being sampled this cycle.
  always_comb begin
    snap_n = snap;
    snap_n[{r, 2'b00} +: 4] = col_s2;
  end
  always_comb begin
    code = '0;
    for (int i = 0; i < 4; i++) begin
      code[i]     = |snap_n[4*i +: 4];
      code[4 + i] = snap_n[i] | snap_n[4 + i] | snap_n[8 + i] | snap_n[12 + i];
    end
  end
  assign none   = snap_n == '0;
  assign single = $onehot(snap_n);
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= '0;
      kpyd  <= '0;
      valid <= 1'b0;
    end else case (state)
      IDLE: if (scan_done && single) begin
        cand <= code;
        cnt  <= CW'(1);
        if (DS == CW'(1)) begin
          state <= PRESENT;
          kpyd  <= code;
          valid <= 1'b1;
        end else state <= DEBOUNCE;
      end
      DEBOUNCE: if (scan_done) begin
        if (!single) begin
          cnt   <= '0;
          state <= IDLE;
        end else if (code != cand) begin
          cand <= code;
          cnt  <= CW'(1);
        end else begin
          cnt <= cnt_inc;
          if (cnt_inc == DS) begin
            state <= PRESENT;
            kpyd  <= cand;
            valid <= 1'b1;
          end
        end
      end
      PRESENT: if (kp.ready) begin
        valid <= 1'b0;
        cnt   <= '0;
        state <= WAIT_RELEASE;
      end
      WAIT_RELEASE: if (scan_done) begin
        if (none) begin
          cnt <= cnt_inc;
          if (cnt_inc == DS) state <= IDLE;
        end else cnt <= '0;
      end
      default: state <= IDLE;
    endcase
  end
endmodule

// File: tb/tb_kpyd_scan_ctrl.sv
// tb_kpyd_scan_ctrl: directed keypad scenarios with a matrix model and hand-computed timing.
module tb_kpyd_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] keys;
  int          checks = 0, fails = 0;
  int          cyc_no = 0, vcnt = 0, xfer = 0, v0, bad;
  logic [7:0]  xcode = '0;
  kpyd_scan_ctrl_if kp();
  kpyd_scan_ctrl #(.SCAN_CYCLES(4), .DEBOUNCE_SCANS(3)) dut (
    .clk_i(clk),
    .reset_n_i(rst_n),
    .kp(kp)
  );
  always #5 clk = ~clk;
  // Key at bit 4*row+col closes the switch between that row and column.
  always_comb begin
    kp.col = '0;
    for (int c = 0; c < 4; c++)
      for (int q = 0; q < 4; q++)
        if (kp.row[q] && keys[4*q + c]) kp.col[c] = 1'b1;
  end
  always @(posedge clk) begin
    cyc_no <= rst_n ? cyc_no + 1 : 0;
    if (kp.valid) vcnt <= vcnt + 1;
    if (kp.valid && kp.ready) begin
      xfer  <= xfer + 1;
      xcode <= kp.kpyd;
    end
  end
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic align();
    while (cyc_no % 16 != 0) @(negedge clk);
  endtask
  initial begin
    rst_n = 1'b0;
    keys = '0;
    kp.ready = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    check("rst_row", 32'(kp.row), 32'h1);
    check("rst_valid", 32'(kp.valid), 0);
    check("rst_kpyd", 32'(kp.kpyd), 0);
    check("rst_busy", 32'(kp.busy), 0);
    for (int i = 1; i <= 4; i++) begin
      cyc(4);
      check("row_step", 32'(kp.row), 32'(1) << (i % 4));
    end
    keys = 16'h0040;
    cyc(47);
    check("press_early", 32'(kp.valid), 0);
    cyc(1);
    check("press_valid", 32'(kp.valid), 1);
    check("press_kpyd", 32'(kp.kpyd), 32'h42);
    check("press_busy", 32'(kp.busy), 1);
    cyc(1);
    check("press_drop", 32'(kp.valid), 0);
    check("press_xcode", 32'(xcode), 32'h42);
    cyc(160);
    check("hold_vcnt", 32'(vcnt), 1);
    check("hold_xfer", 32'(xfer), 1);
    align();
    keys = '0;
    cyc(32);
    keys = 16'h0040;
    cyc(64);
    check("repress_xfer", 32'(xfer), 1);
    align();
    keys = '0;
    cyc(48);
    check("release_idle", 32'(kp.busy), 0);
    v0 = vcnt;
    for (int t = 0; t < 32; t++) begin
      keys = ((t / 5) % 2 == 0) ? 16'h8000 : 16'h0000;
      @(negedge clk);
    end
    keys = 16'h8000;
    cyc(47);
    check("bounce_valid", 32'(kp.valid), 0);
    check("bounce_quiet", 32'(vcnt - v0), 0);
    cyc(1);
    check("bounce_accept", 32'(kp.valid), 1);
    check("bounce_kpyd", 32'(kp.kpyd), 32'h88);
    cyc(1);
    check("bounce_xcode", 32'(xcode), 32'h88);
    align();
    keys = '0;
    cyc(48);
    kp.ready = 1'b0;
    keys = 16'h0001;
    cyc(48);
    check("bp_valid", 32'(kp.valid), 1);
    check("bp_kpyd", 32'(kp.kpyd), 32'h11);
    keys = '0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (!(kp.valid && kp.kpyd == 8'h11)) bad++;
    end
    check("bp_hold", 32'(bad), 0);
    kp.ready = 1'b1;
    cyc(1);
    check("bp_drop", 32'(kp.valid), 0);
    check("bp_xcode", 32'(xcode), 32'h11);
    align();
    cyc(48);
    check("bp_release", 32'(kp.busy), 0);
    keys = 16'h0201;
    v0 = vcnt;
    cyc(64);
    check("ghost_quiet", 32'(vcnt - v0), 0);
    check("ghost_idle", 32'(kp.busy), 0);
    keys = 16'h0001;
    v0 = xfer;
    cyc(48);
    check("ghost_valid", 32'(kp.valid), 1);
    check("ghost_kpyd", 32'(kp.kpyd), 32'h11);
    cyc(1);
    check("ghost_xfer", 32'(xfer - v0), 1);
    align();
    keys = '0;
    cyc(48);
    kp.ready = 1'b0;
    keys = 16'h0020;
    cyc(48);
    check("rp_valid", 32'(kp.valid), 1);
    check("rp_kpyd", 32'(kp.kpyd), 32'h22);
    rst_n = 1'b0;
    cyc(1);
    check("rp_valid_rst", 32'(kp.valid), 0);
    check("rp_kpyd_rst", 32'(kp.kpyd), 0);
    check("rp_row_rst", 32'(kp.row), 32'h1);
    check("rp_busy_rst", 32'(kp.busy), 0);
    rst_n = 1'b1;
    keys = '0;
    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
